// File: rtl/disaggregator.sv
// Wide-to-narrow serializer: pops FETCH_WIDTH*DATA_WIDTH words, emits DATA_WIDTH slices.
// Optional DISAGGREGATOR_STATS_EN adds words_sent / wide_words_done counters.
module disaggregator #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 4,
  parameter int CNT_WIDTH   = $clog2(FETCH_WIDTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [CNT_WIDTH-1:0]              input_fetch_width
`ifdef DISAGGREGATOR_STATS_EN
  ,
  output logic [15:0]                       words_sent,
  output logic [15:0]                       wide_words_done
`endif
);

  localparam int W = FETCH_WIDTH * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] FW_MAX = CNT_WIDTH'(FETCH_WIDTH);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         shift_q, shift_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] fw_q, fw_d;
  logic [CNT_WIDTH-1:0] pend_fw_q, pend_fw_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] req_fw;
  logic                 last_enq;
  logic                 boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      fw_q      <= FW_MAX;
      pend_fw_q <= FW_MAX;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      fw_q      <= fw_d;
      pend_fw_q <= pend_fw_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    req_fw = input_fetch_width;
    if (input_fetch_width == '0 ||
        input_fetch_width > FW_MAX)
      req_fw = FW_MAX;

    receiver_enq  = (state_q == SEND) &&
                    receiver_full_n;
    last_enq      = receiver_enq &&
                    (cnt_q == fw_q - ONE);
    boundary      = (state_q == IDLE) || last_enq;
    sender_deq    = sender_empty_n && boundary;
    receiver_data = shift_q[DATA_WIDTH-1:0];

    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    fw_d      = fw_q;
    pend_fw_d = pend_fw_q;
    pend_d    = pend_q;

    unique case (1'b1)
      sender_deq: begin
        state_d = SEND;
        shift_d = sender_data;
        cnt_d   = '0;
      end
      receiver_enq && !sender_deq: begin
        shift_d = {{DATA_WIDTH{1'b0}},
                   shift_q[W-1:DATA_WIDTH]};
        cnt_d   = cnt_q + ONE;
        if (last_enq)
          state_d = IDLE;
      end
      default: ;
    endcase

    // a fresh request at a boundary beats the older pending one
    if (boundary) begin
      if (change_fetch_width)
        fw_d = req_fw;
      else if (pend_q)
        fw_d = pend_fw_q;
      pend_d = 1'b0;
    end else if (change_fetch_width) begin
      pend_fw_d = req_fw;
      pend_d    = 1'b1;
    end
  end

`ifdef DISAGGREGATOR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_sent      <= '0;
      wide_words_done <= '0;
    end else begin
      if (receiver_enq)
        words_sent <= words_sent + 16'd1;
      if (last_enq)
        wide_words_done <= wide_words_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_disaggregator.sv
// Scoreboard bench for disaggregator: model emits slices per popped word.
// Each word uses the latest clamped width requested at or before its pop.
module tb_disaggregator;
  localparam int DW = 8;
  localparam int FW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   sender_data = '0;
  logic          sender_empty_n = 1'b0;
  logic          sender_deq;
  logic [7:0]    receiver_data;
  logic          receiver_full_n = 1'b1;
  logic          receiver_enq;
  logic          change_fetch_width = 1'b0;
  logic [CW-1:0] input_fetch_width = '0;
`ifdef DISAGGREGATOR_STATS_EN
  logic [15:0]   words_sent;
  logic [15:0]   wide_words_done;
`endif

  disaggregator #(
    .DATA_WIDTH(DW), .FETCH_WIDTH(FW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sender_data(sender_data),
    .sender_empty_n(sender_empty_n),
    .sender_deq(sender_deq),
    .receiver_data(receiver_data),
    .receiver_full_n(receiver_full_n),
    .receiver_enq(receiver_enq),
    .change_fetch_width(change_fetch_width),
    .input_fetch_width(input_fetch_width)
`ifdef DISAGGREGATOR_STATS_EN
    ,
    .words_sent(words_sent),
    .wide_words_done(wide_words_done)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] sq[$];
  logic [7:0]  exp_q[$];
  int enq_log[$];
  int deq_log[$];
  int mfw = FW;
  bit pop_pend = 0;
  bit rand_full = 0;
  bit chg_req = 0;
  int chg_val = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampw(int v);
    return (v == 0 || v > FW) ? FW : v;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               n, a, e, $time);
    end
  endtask

  task automatic step();
    logic [31:0] w;
    @(negedge clk);
    if (pop_pend) begin
      void'(sq.pop_front());
      pop_pend = 0;
    end
    sender_empty_n = (sq.size() != 0);
    sender_data = (sq.size() != 0) ? sq[0] : '0;
    receiver_full_n = rand_full ?
      1'($urandom_range(0, 1)) : 1'b1;
    change_fetch_width = chg_req;
    input_fetch_width = chg_val[CW-1:0];
    if (chg_req) mfw = clampw(chg_val);
    chg_req = 0;
    #1;
    if (sq.size() == 0)
      chk("deq_when_empty", sender_deq, 0);
    else if (rst_n && sender_deq) begin
      w = sq[0];
      for (int s = 0; s < mfw; s++)
        exp_q.push_back(w[s*DW +: DW]);
      pop_pend = 1;
      deq_log.push_back(cyc);
    end
    #2;
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && receiver_enq) begin
      enq_log.push_back(cyc);
      if (exp_q.size() == 0)
        chk("extra_enq", 0, 1);
      else
        chk("slice", receiver_data, exp_q.pop_front());
    end
  end

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || sq.size() != 0 ||
            pop_pend) && b < 3000) begin
      step();
      b++;
    end
    chk("drain", exp_q.size() + sq.size(), 0);
    rand_full = 0;
    step();
    step();
    chk("idle_enq", receiver_enq, 0);
  endtask

  task automatic clr();
    enq_log.delete();
    deq_log.delete();
  endtask

  task automatic chg(input int v);
    chg_req = 1;
    chg_val = v;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int b;
    #3;
    chk("rst_enq", receiver_enq, 0);
    chk("rst_deq", sender_deq, 0);
    chk("rst_data", receiver_data, 0);
`ifdef DISAGGREGATOR_STATS_EN
    chk("rst_ws", words_sent, 0);
    chk("rst_wd", wide_words_done, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // single word, latency
    clr();
    sq.push_back(32'h44332211);
    drain();
    chk("t1_ndeq", deq_log.size(), 1);
    chk("t1_nenq", enq_log.size(), 4);
    if (deq_log.size() == 1 && enq_log.size() == 4) begin
      chk("t1_first", enq_log[0], deq_log[0] + 1);
      chk("t1_last", enq_log[3], deq_log[0] + 4);
    end

    // two words back to back
    clr();
    sq.push_back(32'h44332211);
    sq.push_back(32'h88776655);
    drain();
    chk("t2_ndeq", deq_log.size(), 2);
    chk("t2_nenq", enq_log.size(), 8);
    if (deq_log.size() == 2 && enq_log.size() == 8) begin
      chk("t2_deq4", deq_log[1], enq_log[3]);
      chk("t2_nobub", enq_log[7], deq_log[0] + 8);
    end

    // 64 words incrementing bytes, random backpressure
    clr();
    rand_full = 1;
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      sq.push_back(w);
    end
    drain();
    chk("t3_nenq", enq_log.size(), 256);

    // width change during 2nd slice
    clr();
    sq.push_back(32'h44332211);
    sq.push_back(32'h88776655);
    step();
    step();
    chg_req = 1;
    chg_val = 2;
    step();
    drain();
    chk("t4_nenq", enq_log.size(), 6);

    // clamping and width 1
    clr();
    chg(0);
    sq.push_back(32'h44332211);
    drain();
    chk("t5_w0", enq_log.size(), 4);
    clr();
    chg(2);
    chg(7);
    sq.push_back(32'h44332211);
    drain();
    chk("t5_w7", enq_log.size(), 4);
    clr();
    chg(1);
    sq.push_back(32'h44332211);
    sq.push_back(32'h88776655);
    drain();
    chk("t5_w1", enq_log.size(), 2);

    // random data, random width changes in flight
    clr();
    b = 0;
    for (int n = 0; n < 100 && b < 5000; b++) begin
      rand_full = 1;
      if (sq.size() < 4 && $urandom_range(0, 1) == 1) begin
        sq.push_back($urandom);
        n++;
      end
      if ($urandom_range(0, 9) == 0) begin
        chg_req = 1;
        chg_val = $urandom_range(0, 7);
      end
      step();
    end
    drain();

    // reset mid-word
    chg(4);
    clr();
    sq.push_back(32'h44332211);
    b = 0;
    while (enq_log.size() < 2 && b < 50) begin
      step();
      b++;
    end
    chk("t6_pre", enq_log.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_enq", receiver_enq, 0);
    chk("t6_deq", sender_deq, 0);
    chk("t6_data", receiver_data, 0);
    exp_q.delete();
    sq.delete();
    pop_pend = 0;
    mfw = FW;
`ifdef DISAGGREGATOR_STATS_EN
    chk("t6_ws0", words_sent, 0);
    chk("t6_wd0", wide_words_done, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    chk("t6_quiet", enq_log.size(), 2);

    clr();
    sq.push_back(32'h44332211);
    sq.push_back(32'h88776655);
    drain();
    chk("t7_nenq", enq_log.size(), 8);
`ifdef DISAGGREGATOR_STATS_EN
    chk("t7_ws", words_sent, 8);
    chk("t7_wd", wide_words_done, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
